// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed hex 7-segment scan controller with frame-aligned double buffering.
// Ports: clk, rst_n (sync, active-low), en, load_valid/load_ready/load_data (nibble 0 = digit 0),
//        seg {a..g}, dig_en (one-hot), frame_done (pulse in first cycle of each frame).
// Optional: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never blanked).
module seg7_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 1000,
  parameter int GAP    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_done
);
  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(DIV > GAP ? DIV : GAP) + 1;
  typedef enum logic [1:0] {S_OFF, S_SCAN, S_GAP} state_t;
  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d, shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [6:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     dig_en_q, dig_en_d;
  logic                  frame_done_q, frame_done_d;
  logic                  load_ready_q, load_ready_d;
  logic                  adv, wrap, accept, blank;
  logic [3:0]            nib;
  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: dec = 7'h7E; 4'h1: dec = 7'h30; 4'h2: dec = 7'h6D; 4'h3: dec = 7'h79;
      4'h4: dec = 7'h33; 4'h5: dec = 7'h5B; 4'h6: dec = 7'h5F; 4'h7: dec = 7'h70;
      4'h8: dec = 7'h7F; 4'h9: dec = 7'h7B; 4'hA: dec = 7'h77; 4'hB: dec = 7'h1F;
      4'hC: dec = 7'h4E; 4'hD: dec = 7'h3D; 4'hE: dec = 7'h4F; default: dec = 7'h47;
    endcase
  endfunction
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    adv     = 1'b0;
    wrap    = 1'b0;
    if (!en) begin
      state_d = S_OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == S_OFF) begin
      state_d = S_SCAN;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == S_SCAN && cnt_q == CW'(DIV - 1)) begin
      cnt_d   = '0;
      state_d = GAP > 0 ? S_GAP : S_SCAN;
      adv     = GAP == 0;
    end else if (state_q == S_GAP && cnt_q == CW'(GAP - 1)) begin
      cnt_d   = '0;
      state_d = S_SCAN;
      adv     = 1'b1;
    end
    if (adv) begin
      wrap  = idx_q == IW'(DIGITS - 1);
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    // load_ready mirrors ~pending one cycle late, so gate it with the next pending too
    accept       = load_valid & load_ready_q;
    pending_d    = (wrap & pending_q) ? 1'b0 : (accept | pending_q);
    shadow_d     = accept ? load_data : shadow_q;
    disp_d       = (wrap & pending_q) ? shadow_q : disp_q;
    load_ready_d = ~pending_q & ~pending_d;
    frame_done_d = wrap;
    // outputs are computed from next-cycle state so they register with no input-to-output path
    nib = 4'(disp_d >> (4 * idx_d));
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    blank = (idx_d != '0) && ((disp_d >> (4 * idx_d)) == '0);
`else
    blank = 1'b0;
`endif
    seg_d    = (state_d == S_SCAN && !blank) ? dec(nib) : 7'h00;
    dig_en_d = state_d == S_SCAN ? DIGITS'(1) << idx_d : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_OFF;
      idx_q        <= '0;
      cnt_q        <= '0;
      disp_q       <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      seg_q        <= '0;
      dig_en_q     <= '0;
      frame_done_q <= 1'b0;
      load_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
      frame_done_q <= frame_done_d;
      load_ready_q <= load_ready_d;
    end
  end
  assign seg        = seg_q;
  assign dig_en     = dig_en_q;
  assign frame_done = frame_done_q;
  assign load_ready = load_ready_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed bench for seg7_scan_ctrl with DIGITS=4, DIV=4, GAP=1.
module tb_seg7_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic        frame_done;
  logic        nxt_v = 1'b0;
  logic [15:0] nxt_d = '0;
  int          checks = 0;
  int          errors = 0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] Z = 7'h00;
`else
  localparam logic [6:0] Z = 7'h7E;
`endif
  seg7_scan_ctrl #(.DIGITS(4), .DIV(4), .GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .seg(seg), .dig_en(dig_en), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_dark(input string tag);
    chk({tag, " dig_en"}, 32'(dig_en), 0);
    chk({tag, " seg"}, 32'(seg), 0);
    chk({tag, " frame_done"}, 32'(frame_done), 0);
  endtask
  task automatic frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                       input logic [6:0] s3, input logic fd0, input logic [19:0] lr);
    logic [6:0] s [4];
    int d;
    logic lit, acc;
    s = '{s0, s1, s2, s3};
    for (int p = 0; p < 20; p++) begin
      d   = p / 5;
      lit = (p % 5) < 4;
      chk("dig_en", 32'(dig_en), lit ? (32'd1 << d) : 32'd0);
      chk("seg", 32'(seg), lit ? 32'(s[d]) : 32'd0);
      chk("frame_done", 32'(frame_done), p == 0 ? 32'(fd0) : 32'd0);
      chk("load_ready", 32'(load_ready), 32'(lr[p]));
      acc = load_valid & load_ready;
      step();
      if (acc) begin
        load_valid = nxt_v;
        load_data  = nxt_d;
        nxt_v      = 1'b0;
      end
    end
  endtask
  initial begin
    repeat (3) step();
    chk("rst dig_en", 32'(dig_en), 0);
    chk("rst seg", 32'(seg), 0);
    chk("rst frame_done", 32'(frame_done), 0);
    chk("rst load_ready", 32'(load_ready), 0);
    rst_n = 1'b1;
    step();
    chk("idle load_ready", 32'(load_ready), 1);
    chk_dark("idle");
    step();
    chk_dark("idle2");
    load_valid = 1'b1;
    load_data  = 16'h1234;
    step();
    load_valid = 1'b0;
    chk("pend load_ready", 32'(load_ready), 0);
    en = 1'b1;
    step();
    frame(7'h7E, 7'h7E, 7'h7E, 7'h7E, 1'b0, 20'h00000);
    load_valid = 1'b1;
    load_data  = 16'hABCD;
    nxt_v      = 1'b1;
    nxt_d      = 16'h5678;
    frame(7'h33, 7'h79, 7'h6D, 7'h30, 1'b1, 20'h00002);
    frame(7'h3D, 7'h4E, 7'h1F, 7'h77, 1'b1, 20'h00002);
    frame(7'h7F, 7'h70, 7'h5F, 7'h5B, 1'b1, 20'hFFFFE);
    chk("wrap frame_done", 32'(frame_done), 1);
    repeat (11) step();
    chk("digit2 dig_en", 32'(dig_en), 4'b0100);
    en = 1'b0;
    step();
    chk_dark("en drop");
    for (int i = 0; i < 25; i++) begin
      step();
      chk_dark("off");
    end
    en = 1'b1;
    step();
    load_valid = 1'b1;
    load_data  = 16'h0050;
    frame(7'h7F, 7'h70, 7'h5F, 7'h5B, 1'b0, 20'h00001);
    frame(7'h7E, 7'h5B, Z, Z, 1'b1, 20'hFFFFE);
    chk("lz frame_done", 32'(frame_done), 1);
    step();
    chk("pre rst load_ready", 32'(load_ready), 1);
    load_valid = 1'b1;
    load_data  = 16'h9999;
    step();
    load_valid = 1'b0;
    chk("9999 load_ready", 32'(load_ready), 0);
    rst_n = 1'b0;
    step();
    chk_dark("mid rst");
    chk("mid rst load_ready", 32'(load_ready), 0);
    rst_n = 1'b1;
    step();
    frame(7'h7E, 7'h7E, 7'h7E, 7'h7E, 1'b0, 20'hFFFFF);
    chk("post rst frame_done", 32'(frame_done), 1);
    chk("post rst seg", 32'(seg), 7'h7E);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
